// File: rtl/text_line_renderer.sv
`default_nettype none
// ============================================================================
// Module   : text_line_renderer
// Purpose  : Four-stage read pipeline from the HUD text RAM and the 8x16 font
//            ROM to a per-pixel text_on flag. Define TEXT_BLINK_EN to add
//            blinking for characters that have bit 7 set.
// Revision : 1.0 - initial release
// ============================================================================
module text_line_renderer #(
    parameter int TEXT_X0 = 16,
    parameter int TEXT_Y0 = 8,
    parameter int COLS    = 40,
    parameter int LINES   = 4,
    parameter int ADDR_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pixel_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] read_address,
    input  logic [7:0]        char_code,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic              text_on,
    output logic              out_valid
);

    localparam logic [10:0] c_X_LO = 11'(TEXT_X0);
    localparam logic [10:0] c_X_HI = 11'(TEXT_X0 + 8 * COLS);
    localparam logic [10:0] c_Y_LO = 11'(TEXT_Y0);
    localparam logic [10:0] c_Y_HI = 11'(TEXT_Y0 + 16 * LINES);

    logic [9:0]        w_dx, w_dy;
    logic              w_inwin;
    logic [ADDR_W-1:0] w_col, w_line;
    logic              w_blink_off;

    logic [ADDR_W-1:0] read_address_q, read_address_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_inwin_q, s1_inwin_d;
    logic [2:0]        s1_px_q, s1_px_d;
    logic [3:0]        s1_row_q, s1_row_d;
    logic              s2_valid_q, s2_inwin_q;
    logic [2:0]        s2_px_q;
    logic [3:0]        s2_row_q;
    logic              s3_valid_q, s3_inwin_q, s3_blank_q;
    logic [2:0]        s3_px_q;
    logic              text_on_q, out_valid_q;

    assign w_dx    = DrawX - c_X_LO[9:0];
    assign w_dy    = DrawY - c_Y_LO[9:0];
    assign w_inwin = ({1'b0, DrawX} >= c_X_LO) && ({1'b0, DrawX} < c_X_HI) &&
                     ({1'b0, DrawY} >= c_Y_LO) && ({1'b0, DrawY} < c_Y_HI);
    assign w_col   = ADDR_W'(w_dx[9:3]);
    assign w_line  = ADDR_W'(w_dy[9:4]);

    always_comb begin
        read_address_d = read_address_q;
        s1_valid_d     = pixel_en;
        s1_inwin_d     = pixel_en & w_inwin;
        s1_px_d        = w_dx[2:0];
        s1_row_d       = w_dy[3:0];
        if (pixel_en && w_inwin) begin
            read_address_d = w_line * ADDR_W'(COLS) + w_col;
        end
    end

`ifdef TEXT_BLINK_EN
    logic [5:0] frame_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q <= 6'd0;
        end else if (pixel_en && DrawX == 10'd0 && DrawY == 10'd0) begin
            frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    // Blinking characters spend the upper half of the 64-frame period dark.
    assign w_blink_off = char_code[7] & frame_cnt_q[5];
`else
    logic unused_blink;
    assign unused_blink = char_code[7];
    assign w_blink_off  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address_q <= '0;
            s1_valid_q     <= 1'b0;
            s1_inwin_q     <= 1'b0;
            s1_px_q        <= 3'd0;
            s1_row_q       <= 4'd0;
            s2_valid_q     <= 1'b0;
            s2_inwin_q     <= 1'b0;
            s2_px_q        <= 3'd0;
            s2_row_q       <= 4'd0;
            s3_valid_q     <= 1'b0;
            s3_inwin_q     <= 1'b0;
            s3_blank_q     <= 1'b0;
            s3_px_q        <= 3'd0;
            text_on_q      <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            read_address_q <= read_address_d;
            s1_valid_q     <= s1_valid_d;
            s1_inwin_q     <= s1_inwin_d;
            s1_px_q        <= s1_px_d;
            s1_row_q       <= s1_row_d;
            s2_valid_q     <= s1_valid_q;
            s2_inwin_q     <= s1_inwin_q;
            s2_px_q        <= s1_px_q;
            s2_row_q       <= s1_row_q;
            s3_valid_q     <= s2_valid_q;
            s3_inwin_q     <= s2_inwin_q;
            s3_px_q        <= s2_px_q;
            s3_blank_q     <= (char_code[6:0] < 7'h20) | w_blink_off;
            // Bit 7 is the leftmost pixel, so the bit index is 7-px, i.e. ~px.
            text_on_q      <= s3_valid_q & s3_inwin_q & ~s3_blank_q & font_data[~s3_px_q];
            out_valid_q    <= s3_valid_q;
        end
    end

    assign read_address = read_address_q;
    assign font_addr    = {char_code[6:0], s2_row_q};
    assign text_on      = text_on_q;
    assign out_valid    = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_text_line_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_line_renderer
// Purpose  : Scoreboard bench for text_line_renderer with RAM and font models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_line_renderer;

    localparam int X0 = 16;
    localparam int Y0 = 8;
    localparam int COLS = 40;
    localparam int LINES = 4;
`ifdef TEXT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pixel_en;
    logic [9:0]  DrawX, DrawY;
    logic [7:0]  read_address;
    logic [7:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        text_on, out_valid;

    always #5 Clk = ~Clk;

    text_line_renderer #(
        .TEXT_X0(X0), .TEXT_Y0(Y0), .COLS(COLS), .LINES(LINES), .ADDR_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
        .read_address(read_address), .char_code(char_code), .font_addr(font_addr),
        .font_data(font_data), .text_on(text_on), .out_valid(out_valid)
    );

    logic [7:0] ram      [0:255];
    logic [7:0] font_mem [0:2047];

    always @(posedge Clk) begin
        char_code <= ram[read_address];
        font_data <= font_mem[font_addr];
    end

    typedef struct packed { logic v; logic t; } exp_t;
    typedef struct packed { logic chk; logic [10:0] fa; } fa_t;

    exp_t exp_q[$];
    fa_t  fa_q[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] m_addr = 8'd0;
    int   m_frame = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge: check outputs, drive the next pixel, advance one cycle.
    task automatic step(input logic rst, input logic en, input int x, input int y);
        exp_t e;
        fa_t  f;
        logic inwin, lit, blank;
        logic [7:0] c, glyph;
        logic [3:0] row;
        logic [2:0] px;
        chk("read_address", 32'(read_address), 32'(m_addr));
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("text_on", 32'(text_on), 32'(e.t));
        end else begin
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_text_on", 32'(text_on), 32'd0);
        end
        if (fa_q.size() == 2) begin
            f = fa_q.pop_front();
            if (f.chk) chk("font_addr", 32'(font_addr), 32'(f.fa));
        end
        Reset = rst; pixel_en = en; DrawX = 10'(x); DrawY = 10'(y);
        inwin = (x >= X0) && (x < X0 + 8 * COLS) && (y >= Y0) && (y < Y0 + 16 * LINES);
        if (rst) begin
            exp_q.delete();
            fa_q.delete();
            m_addr = 8'd0;
            m_frame = 0;
            exp_q.push_back('{v: 1'b0, t: 1'b0});
            fa_q.push_back('{chk: 1'b0, fa: 11'd0});
        end else begin
            if (en && inwin) m_addr = 8'(((y - Y0) / 16) * COLS + (x - X0) / 8);
            c     = ram[m_addr];
            row   = 4'((y - Y0) & 15);
            px    = 3'((x - X0) & 7);
            glyph = font_mem[{c[6:0], row}];
            lit   = glyph[7 - px];
            blank = (c[6:0] < 7'h20) || (BLINK && c[7] && m_frame >= 32);
            exp_q.push_back('{v: en, t: en && inwin && !blank && lit});
            fa_q.push_back('{chk: en && inwin, fa: {c[6:0], row}});
            if (en && x == 0 && y == 0) m_frame = (m_frame + 1) % 64;
        end
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(8'h20 + (i * 7) % 90);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'((i * 37) ^ (i >> 3));
        ram[0]  = 8'h00;
        ram[43] = 8'h53;
        ram[50] = 8'hC1;
        font_mem[{7'h53, 4'd5}] = 8'h80;
        for (int r = 0; r < 16; r++) begin
            font_mem[{7'h00, 4'(r)}] = 8'hFF;
            font_mem[{7'h41, 4'(r)}] = 8'hFF;
        end

        Reset = 1'b1; pixel_en = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);

        // Reset for two cycles with the raster running, then release.
        step(1'b1, 1'b1, X0, Y0);
        step(1'b1, 1'b1, X0 + 1, Y0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, X0 + 2 + i, Y0);

        // Address and pixel select: char 0x53 row 5, font 0x80.
        step(1'b0, 1'b1, X0 + 24, Y0 + 21);
        step(1'b0, 1'b1, X0 + 25, Y0 + 21);

        // Window edges.
        step(1'b0, 1'b1, X0 - 1, Y0 + 21);
        step(1'b0, 1'b1, X0 + 320, Y0 + 21);
        step(1'b0, 1'b1, X0 + 24, Y0 + 64);
        step(1'b0, 1'b1, X0 + 319, Y0 + 63);

        // Blank char 0x00 with font 0xFF.
        step(1'b0, 1'b1, X0, Y0 + 3);
        step(1'b0, 1'b1, X0 + 5, Y0 + 9);

        // Random raster traffic around the window.
        for (int i = 0; i < 200; i++)
            step(1'b0, ($urandom % 4) != 0, X0 - 4 + int'($urandom_range(0, 330)),
                 Y0 - 2 + int'($urandom_range(0, 68)));

        // pixel_en gaps inside the window.
        for (int i = 0; i < 16; i++) step(1'b0, (i % 2) == 0, X0 + 80 + i, Y0 + 18);

        // Mid-stream reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, X0 + 40 + i, Y0 + 30);
        step(1'b1, 1'b1, X0 + 43, Y0 + 30);
        step(1'b1, 1'b1, X0 + 44, Y0 + 30);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, X0 + 45 + i, Y0 + 30);

        // Blink char 0xC1 across 65 frames (frame counter wraps back to 0).
        for (int f = 0; f <= 64; f++) begin
            if (f != 0) step(1'b0, 1'b1, 0, 0);
            for (int p = 0; p < 4; p++) step(1'b0, 1'b1, X0 + 80 + p, Y0 + 16 + 2);
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 500, 500);
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 500, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
